mult8x8_seq: RTL and testbench

MULT8X8_SEQ -- requirements
Module: mult8x8_seq

---
 rtl/mult8x8_seq.sv | 122 ++++++++++++
 tb/tb_mult8x8_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mult8x8_seq.sv
// mult8x8_seq: 8x8 unsigned sequential multiplier. It builds the product from four
// nibble partial products, computed one per cycle by a single shared 4x4 Multiplier.
`default_nettype none

module Multiplier (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] C
);
  assign C = A * B;
endmodule

module mult8x8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [1:0]  step, step_n;
  logic [7:0]  a_q, a_n;
  logic [7:0]  b_q, b_n;
  logic [15:0] acc, acc_n;

  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] addend;

  // step[0] selects the high nibble of a, step[1] the high nibble of b
  assign nib_a = step[0] ? a_q[7:4] : a_q[3:0];
  assign nib_b = step[1] ? b_q[7:4] : b_q[3:0];

  Multiplier u_mul (
    .A (nib_a),
    .B (nib_b),
    .C (pp)
  );

  always_comb begin
    addend = 16'h0000;
    case (step)
      2'd0:    addend = {8'h00, pp};
      2'd1,
      2'd2:    addend = {4'h0, pp, 4'h0};
      default: addend = {pp, 8'h00};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= 2'd0;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      acc   <= 16'h0000;
    end else begin
      state <= state_n;
      step  <= step_n;
      a_q   <= a_n;
      b_q   <= b_n;
      acc   <= acc_n;
    end
  end

  always_comb begin
    state_n   = state;
    step_n    = step;
    a_n       = a_q;
    b_n       = b_q;
    acc_n     = acc;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_n     = a;
          b_n     = b;
          acc_n   = 16'h0000;
          step_n  = 2'd0;
          state_n = CALC;
        end
      end
      CALC: begin
        // Largest possible sum is 0xFE01, so the 16-bit add never overflows
        acc_n  = acc + addend;
        step_n = step + 2'd1;
        if (step == 2'd3) begin
          state_n = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign p    = acc;
  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult8x8_seq.sv
// tb_mult8x8_seq: self-checking bench for mult8x8_seq. It runs directed cases and then
// a randomized regression checked against a queue-based a*b reference.
`default_nettype none

module tb_mult8x8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mult8x8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    tick; tick;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100 || p !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b p=%h, expected 1 0 0 0000",
               in_ready, out_valid, busy, p);
    end
    rst_n = 1'b1;
    tick;
  endtask

  // One complete transaction: accept, 4-cycle latency, bp cycles of back-pressure, handshake.
  // During calculation a and b are driven to 0xFF; the latched operands must still be used.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input int bp);
    logic [15:0] exp_p;
    int n;
    exp_p = 16'(x) * 16'(y);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_op: in_ready=%b expected 1", in_ready);
    end
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0; a = 8'hFF; b = 8'hFF;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("FAIL latency %h*%h: %0d cycles, expected 4", x, y, n);
    end
    vectors++;
    if (p !== exp_p || busy !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL product %h*%h: p=%h busy=%b in_ready=%b, expected p=%h busy=1 in_ready=0",
               x, y, p, busy, in_ready, exp_p);
    end
    for (int i = 0; i < bp; i++) begin
      tick;
      vectors++;
      if (out_valid !== 1'b1 || p !== exp_p || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure cycle %0d: out_valid=%b p=%h in_ready=%b, expected 1 %h 0",
                 i, out_valid, p, in_ready, exp_p);
      end
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_handshake: in_ready=%b out_valid=%b busy=%b, expected 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_full_scale;
    run_op(8'hFF, 8'hFF, 0);
  endtask

  task automatic test_mixed_and_zero;
    run_op(8'hA5, 8'h3C, 0);
    run_op(8'h00, 8'h7F, 0);
    run_op(8'h7F, 8'h00, 1);
  endtask

  task automatic test_backpressure;
    run_op(8'h12, 8'h34, 10);
  endtask

  task automatic test_operand_stability;
    run_op(8'h0F, 8'hF0, 0);
  endtask

  task automatic test_reset_mid_op;
    logic spurious;
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    tick;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 16'h0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_op: in_ready=%b out_valid=%b p=%h busy=%b, expected 1 0 0000 0",
               in_ready, out_valid, p, busy);
    end
    rst_n = 1'b1;
    spurious = 1'b0;
    repeat (8) begin
      tick;
      if (out_valid !== 1'b0) spurious = 1'b1;
    end
    vectors++;
    if (spurious) begin
      miscompares++;
      $display("FAIL reset_spurious_output: out_valid seen %b, expected 0", spurious);
    end
    out_ready = 1'b0;
    run_op(8'h03, 8'h05, 0);
  endtask

  task automatic test_random;
    logic [15:0] q[$];
    logic [15:0] e;
    int accepted;
    int cyc;
    accepted = 0;
    cyc      = 0;
    while ((accepted < 10000 || q.size() > 0) && cyc < 90000) begin
      in_valid  = (accepted < 10000) && ($urandom_range(0, 9) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(0, 4) != 0);
      if (out_valid === 1'b1 && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL random_spurious: p=%h with no outstanding request, expected none", p);
        end else begin
          e = q.pop_front();
          if (p !== e) begin
            miscompares++;
            $display("FAIL random_product: p=%h expected %h", p, e);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(16'(a) * 16'(b));
        accepted++;
      end
      tick;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (accepted != 10000 || q.size() != 0) begin
      miscompares++;
      $display("FAIL random_drain: accepted=%0d outstanding=%0d, expected 10000 and 0",
               accepted, q.size());
    end
  endtask

  initial begin
    test_reset;
    test_full_scale;
    test_mixed_and_zero;
    test_backpressure;
    test_operand_stability;
    test_reset_mid_op;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
